// File: rtl/pfpu_seq.sv
// pfpu_seq: multi-cycle pinky-float unit (ADDF/SUBF/MULF/ITOF/FTOI), truncating.
// Define PFPU_STATUS_FLAGS_EN to add the flags port {invalid, overflow, underflow, inexact}.
module pfpu_seq #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 7,
    parameter int W      = 1 + EXP_W + MANT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [4:0]   op,
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result
`ifdef PFPU_STATUS_FLAGS_EN
    ,
    output logic [3:0]   flags
`endif
);

    localparam int SW   = MANT_W + 1;
    localparam int XW   = EXP_W + 2;
    localparam int LZW  = $clog2(W) + 1;
    localparam int BIAS = 2 ** (EXP_W - 1) - 1;
    localparam int EMAX = 2 ** EXP_W - 1;

    localparam logic signed [XW-1:0] BIAS_X = XW'(BIAS);
    localparam logic signed [XW-1:0] EMAX_X = XW'(EMAX);
    localparam logic signed [XW-1:0] WM1_X  = XW'(W - 1);
    localparam logic signed [XW-1:0] ONE_X  = XW'(1);

    localparam logic [4:0] OP_ADDF = 5'h11;
    localparam logic [4:0] OP_FTOI = 5'h12;
    localparam logic [4:0] OP_ITOF = 5'h13;
    localparam logic [4:0] OP_MULF = 5'h14;
    localparam logic [4:0] OP_SUBF = 5'h16;

    typedef enum logic [2:0] {
        S_IDLE, S_ALIGN, S_ARITH, S_NORM, S_PACK
    } state_t;

    state_t state, state_nx;

    logic [4:0]          op_q;
    logic [W-1:0]        a_q, b_q;
    logic                sgn_q, sgn_d;
    logic signed [XW-1:0] exp_q, exp_d;
    logic [SW:0]         sig_q, sig_d;
    logic [SW-1:0]       sml_q, sml_d;
    logic [MANT_W-1:0]   man_q, man_d;
    logic [W-1:0]        int_q, int_d;
    logic                sub_q, sub_d;
    logic                zero_q, zero_d;
    logic                inx_q, inx_d;
    logic                inv_q, inv_d;
    logic [W-1:0]        res_d;
    logic [3:0]          flags_d;

    logic accept;
    logic is_add, is_mul, is_itof, is_ftoi;

    assign accept  = (state == S_IDLE) && start;
    assign is_add  = (op_q == OP_ADDF) || (op_q == OP_SUBF);
    assign is_mul  = (op_q == OP_MULF);
    assign is_itof = (op_q == OP_ITOF);
    assign is_ftoi = (op_q == OP_FTOI);

    logic [EXP_W-1:0]  ea, eb;
    logic              sa, sb_eff;
    logic [SW-1:0]     siga, sigb;
    logic [W-2:0]      ka, kb;

    assign ea     = a_q[W-2 -: EXP_W];
    assign eb     = b_q[W-2 -: EXP_W];
    assign sa     = a_q[W-1];
    assign sb_eff = b_q[W-1] ^ (op_q == OP_SUBF);
    assign siga   = (ea == '0) ? '0 : {1'b1, a_q[MANT_W-1:0]};
    assign sigb   = (eb == '0) ? '0 : {1'b1, b_q[MANT_W-1:0]};
    assign ka     = (ea == '0) ? '0 : a_q[W-2:0];
    assign kb     = (eb == '0) ? '0 : b_q[W-2:0];

    // Alignment: the smaller operand's significand is shifted right and truncated.
    logic              a_big, big_s, sml_s, lost;
    logic [EXP_W-1:0]  big_e, sml_e, diff;
    logic [SW-1:0]     big_sig, sml_sig, sml_al;

    assign a_big   = ka >= kb;
    assign big_e   = a_big ? ea : eb;
    assign sml_e   = a_big ? eb : ea;
    assign big_s   = a_big ? sa : sb_eff;
    assign sml_s   = a_big ? sb_eff : sa;
    assign big_sig = a_big ? siga : sigb;
    assign sml_sig = a_big ? sigb : siga;
    assign diff    = big_e - sml_e;
    assign sml_al  = sml_sig >> diff;
    assign lost    = |(sml_sig & ~({SW{1'b1}} << diff));

    logic [2*SW-1:0]      prod;
    logic signed [XW-1:0] mexp, ue;
    logic [W+MANT_W-1:0]  fsh;
    logic [W-1:0]         fmag;

    assign prod = siga * sigb;
    assign mexp = $signed(XW'(ea)) + $signed(XW'(eb)) - BIAS_X;
    assign ue   = $signed(XW'(eb)) - BIAS_X;
    assign fsh  = (W+MANT_W)'(sigb) << ue[LZW-1:0];
    assign fmag = fsh[W+MANT_W-1:MANT_W];

    function automatic logic [LZW-1:0] lzc(input logic [W-1:0] v);
        logic [LZW-1:0] n;
        n = LZW'(W);
        for (int i = 0; i < W; i++)
            if (v[i]) n = LZW'(W - 1 - i);
        return n;
    endfunction

    // Shared normaliser: add results are left-aligned into the integer width.
    logic [W-1:0]   lz_in, nrm;
    logic [LZW-1:0] lz;

    assign lz_in = is_itof ? int_q : {sig_q[SW-1:0], {EXP_W{1'b0}}};
    assign lz    = lzc(lz_in);
    assign nrm   = lz_in << lz;

    always_comb begin
        state_nx = state;
        busy     = (state != S_IDLE) || done;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    unique case (1'b1)
                        (op == OP_ADDF) || (op == OP_SUBF): state_nx = S_ALIGN;
                        (op == OP_MULF) || (op == OP_FTOI)
                            || (op == OP_ITOF):             state_nx = S_ARITH;
                        default:                            state_nx = S_PACK;
                    endcase
                end
            end
            S_ALIGN: state_nx = S_ARITH;
            S_ARITH: state_nx = (is_add || is_itof) ? S_NORM : S_PACK;
            S_NORM:  state_nx = S_PACK;
            S_PACK:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        sgn_d  = sgn_q;
        exp_d  = exp_q;
        sig_d  = sig_q;
        sml_d  = sml_q;
        man_d  = man_q;
        int_d  = int_q;
        sub_d  = sub_q;
        zero_d = zero_q;
        inx_d  = inx_q;
        inv_d  = inv_q;
        case (state)
            S_ALIGN: begin
                sgn_d  = big_s;
                exp_d  = $signed(XW'(big_e));
                sig_d  = {1'b0, big_sig};
                sml_d  = sml_al;
                sub_d  = big_s ^ sml_s;
                zero_d = (big_e == '0);
                inx_d  = lost;
                inv_d  = 1'b0;
            end
            S_ARITH: begin
                unique case (1'b1)
                    is_add: begin
                        sig_d = sub_q ? sig_q - {1'b0, sml_q}
                                      : sig_q + {1'b0, sml_q};
                    end
                    is_mul: begin
                        sgn_d  = sa ^ b_q[W-1];
                        zero_d = (ea == '0) || (eb == '0);
                        inv_d  = 1'b0;
                        if (prod[2*SW-1]) begin
                            exp_d = mexp + ONE_X;
                            man_d = prod[2*SW-2 -: MANT_W];
                            inx_d = |prod[MANT_W:0];
                        end else begin
                            exp_d = mexp;
                            man_d = prod[2*SW-3 -: MANT_W];
                            inx_d = |prod[MANT_W-1:0];
                        end
                    end
                    is_itof: begin
                        sgn_d  = b_q[W-1];
                        int_d  = b_q[W-1] ? -b_q : b_q;
                        zero_d = (b_q == '0);
                        inx_d  = 1'b0;
                        inv_d  = 1'b0;
                    end
                    is_ftoi: begin
                        sgn_d  = b_q[W-1];
                        zero_d = 1'b0;
                        inv_d  = 1'b0;
                        inx_d  = 1'b0;
                        int_d  = '0;
                        if (eb == '0) begin
                            int_d = '0;
                        end else if (ue[XW-1]) begin
                            inx_d = 1'b1;
                        end else if (ue >= WM1_X) begin
                            inv_d = 1'b1;
                            int_d = b_q[W-1] ? {1'b1, {(W-1){1'b0}}}
                                             : {1'b0, {(W-1){1'b1}}};
                        end else begin
                            inx_d = |fsh[MANT_W-1:0];
                            int_d = b_q[W-1] ? -fmag : fmag;
                        end
                    end
                    default: ;
                endcase
            end
            S_NORM: begin
                if (is_add && sig_q[SW]) begin
                    exp_d  = exp_q + ONE_X;
                    man_d  = sig_q[SW-1:1];
                    inx_d  = inx_q | sig_q[0];
                    zero_d = 1'b0;
                end else begin
                    zero_d = ~nrm[W-1];
                    man_d  = nrm[W-2 -: MANT_W];
                    inx_d  = inx_q | (|nrm[W-2-MANT_W:0]);
                    exp_d  = is_itof ? BIAS_X + WM1_X - $signed(XW'(lz))
                                     : exp_q - $signed(XW'(lz));
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        res_d   = result;
        flags_d = 4'b0000;
        unique case (1'b1)
            is_ftoi: begin
                res_d   = int_q;
                flags_d = {inv_q, 2'b00, inx_q};
            end
            is_add, is_mul, is_itof: begin
                if (zero_q) begin
                    res_d      = '0;
                    flags_d[0] = inx_q;
                end else if (exp_q[XW-1] || (exp_q == '0)) begin
                    res_d   = '0;
                    flags_d = 4'b0011;
                end else if (exp_q > EMAX_X) begin
                    res_d   = {sgn_q, {(W-1){1'b1}}};
                    flags_d = 4'b0101;
                end else begin
                    res_d      = {sgn_q, exp_q[EXP_W-1:0], man_q};
                    flags_d[0] = inx_q;
                end
            end
            default: flags_d = 4'b1000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done   <= 1'b0;
            result <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sgn_q  <= 1'b0;
            exp_q  <= '0;
            sig_q  <= '0;
            sml_q  <= '0;
            man_q  <= '0;
            int_q  <= '0;
            sub_q  <= 1'b0;
            zero_q <= 1'b0;
            inx_q  <= 1'b0;
            inv_q  <= 1'b0;
        end else begin
            done <= (state == S_PACK);
            if (state == S_PACK) result <= res_d;
            if (accept) begin
                op_q <= op;
                a_q  <= op1;
                b_q  <= op2;
            end
            sgn_q  <= sgn_d;
            exp_q  <= exp_d;
            sig_q  <= sig_d;
            sml_q  <= sml_d;
            man_q  <= man_d;
            int_q  <= int_d;
            sub_q  <= sub_d;
            zero_q <= zero_d;
            inx_q  <= inx_d;
            inv_q  <= inv_d;
        end
    end

`ifdef PFPU_STATUS_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 flags <= 4'b0000;
        else if (state == S_PACK)   flags <= flags_d;
    end
`else
    logic unused_flags;
    assign unused_flags = ^flags_d;
`endif

endmodule

// File: tb/tb_pfpu_seq.sv
// tb_pfpu_seq: scoreboard bench for pfpu_seq.
// Expected results and due cycles are queued at launch, popped on done.
module tb_pfpu_seq;

    localparam logic [4:0] ADDF  = 5'h11;
    localparam logic [4:0] FTOI  = 5'h12;
    localparam logic [4:0] ITOF  = 5'h13;
    localparam logic [4:0] MULF  = 5'h14;
    localparam logic [4:0] SUBF  = 5'h16;
    localparam logic [4:0] BADOP = 5'h15;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  op    = '0;
    logic [15:0] op1   = '0;
    logic [15:0] op2   = '0;
    logic        busy, done;
    logic [15:0] result;
`ifdef PFPU_STATUS_FLAGS_EN
    logic [3:0]  flags;
`endif

    typedef struct {
        string       tag;
        logic [15:0] res;
        int          due;
    } exp_t;

    exp_t sbq[$];
    int   cyc      = 0;
    int   n_chk    = 0;
    int   n_err    = 0;
    int   done_cnt = 0;
    int   d0;

    pfpu_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .op1    (op1),
        .op2    (op2),
        .busy   (busy),
        .done   (done),
        .result (result)
`ifdef PFPU_STATUS_FLAGS_EN
        ,
        .flags  (flags)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            done_cnt++;
            if (sbq.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                e = sbq.pop_front();
                check({e.tag, "_res"}, 32'(result), 32'(e.res));
                check({e.tag, "_lat"}, 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic expect_res(input string tag, input logic [15:0] r,
                              input int lat);
        exp_t e;
        e.tag = tag;
        e.res = r;
        e.due = cyc + lat;
        sbq.push_back(e);
    endtask

    task automatic drive(input string tag, input logic [4:0] o,
                         input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] r, input int lat);
        start = 1'b1;
        op    = o;
        op1   = x;
        op2   = y;
        @(posedge clk);
        #1;
        expect_res(tag, r, lat);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
        check("drain", 32'(sbq.size()), 32'd0);
        sbq.delete();
    endtask

    task automatic run(input string tag, input logic [4:0] o,
                       input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] r, input int lat);
        @(negedge clk);
        drive(tag, o, x, y, r, lat);
        drain();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_result", 32'(result), 32'd0);
        rst_n = 1'b1;

        run("itof_5",    ITOF, 16'h0000, 16'h0005, 16'h40A0, 3);
        run("itof_min",  ITOF, 16'h0000, 16'h8000, 16'hC700, 3);
        run("itof_zero", ITOF, 16'h0000, 16'h0000, 16'h0000, 3);
        run("itof_m5",   ITOF, 16'h0000, 16'hFFFB, 16'hC0A0, 3);

        run("mul_9",     MULF, 16'h4040, 16'h4040, 16'h4110, 2);
        run("mul_sat",   MULF, 16'h7F7F, 16'h7F7F, 16'h7FFF, 2);
`ifdef PFPU_STATUS_FLAGS_EN
        check("mul_sat_ovf_flag", 32'(flags[2]), 32'd1);
`endif
        run("mul_zero",  MULF, 16'h0000, 16'h4040, 16'h0000, 2);
        run("mul_neg",   MULF, 16'h4040, 16'hC000, 16'hC0C0, 2);
        run("mul_uflow", MULF, 16'h0080, 16'h0080, 16'h0000, 2);

        run("add_mix",   ADDF, 16'h4040, 16'hBFC0, 16'h3FC0, 4);
        run("add_canc",  ADDF, 16'h3F80, 16'hBF80, 16'h0000, 4);
        run("sub_neg",   SUBF, 16'h4000, 16'h4040, 16'hBF80, 4);
        run("add_carry", ADDF, 16'h3F80, 16'h3F80, 16'h4000, 4);
        run("add_max",   ADDF, 16'h7F7F, 16'h7F7F, 16'h7FFF, 4);
        run("add_far",   ADDF, 16'h4000, 16'h3400, 16'h4000, 4);
        run("add_zero",  ADDF, 16'h0000, 16'hC040, 16'hC040, 4);

        run("ftoi_m50",  FTOI, 16'h0000, 16'hC248, 16'hFFCE, 2);
        run("ftoi_half", FTOI, 16'h0000, 16'h3F00, 16'h0000, 2);
        run("ftoi_psat", FTOI, 16'h0000, 16'h4780, 16'h7FFF, 2);
        run("ftoi_nsat", FTOI, 16'h0000, 16'hC780, 16'h8000, 2);
        run("ftoi_3",    FTOI, 16'h0000, 16'h4040, 16'h0003, 2);

        run("badop",     BADOP, 16'h1234, 16'h5678, 16'h0003, 1);
`ifdef PFPU_STATUS_FLAGS_EN
        check("badop_inv_flag", 32'(flags[3]), 32'd1);
`endif

        // start held high through most of an ADDF: only one op may run
        @(negedge clk);
        d0    = done_cnt;
        start = 1'b1;
        op    = ADDF;
        op1   = 16'h4040;
        op2   = 16'hBFC0;
        @(posedge clk);
        #1;
        expect_res("hold_add", 16'h3FC0, 4);
        op  = MULF;
        op1 = 16'h4040;
        op2 = 16'h4040;
        @(posedge clk);
        #1 check("hold_busy1", 32'(busy), 32'd1);
        @(posedge clk);
        #1 check("hold_busy2", 32'(busy), 32'd1);
        start = 1'b0;
        drain();
        repeat (6) @(negedge clk);
        check("hold_one_done", 32'(done_cnt - d0), 32'd1);

        // back-to-back launch in the done cycle
        @(negedge clk);
        drive("b2b_mul", MULF, 16'h4040, 16'h4040, 16'h4110, 2);
        for (int i = 0; i < 10 && !done; i++) @(negedge clk);
        check("b2b_done_seen",    32'(done), 32'd1);
        check("b2b_busy_in_done", 32'(busy), 32'd1);
        drive("b2b_itof", ITOF, 16'h0000, 16'h0005, 16'h40A0, 3);
        drain();

        // reset two cycles into an ADDF aborts it
        @(negedge clk);
        drive("abort_add", ADDF, 16'h4040, 16'hBFC0, 16'h3FC0, 4);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy",   32'(busy),   32'd0);
        check("abort_done",   32'(done),   32'd0);
        check("abort_result", 32'(result), 32'd0);
        sbq.delete();
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_idle",    32'(busy),          32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
